// File: rtl/lm32_mul_arb_pkg.sv
// Shared types and constants for the lm32 multiplier arbiter.
// Tracking stages carry a tag wide enough for the largest supported NREQ (8).
package lm32_mul_arb_pkg;

    localparam int MUL_LAT  = 3;
    localparam int MAX_TAGW = 3;

    typedef struct packed {
        logic                valid;
        logic [MAX_TAGW-1:0] tag;
    } mul_stage_t;

    // Tag width for n requesters, never narrower than one bit.
    function automatic int tag_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lm32_mul_arb_rr.sv
// NREQ-wide requester picker: round-robin starting at ptr_i, or fixed priority
// (lowest index wins, no pointer port) when CFG_MUL_ARB_FIXED_PRIO_EN is defined.
module lm32_mul_arb_rr
#(
    parameter int NREQ = 2,
    parameter int TAGW = 1
)
(
`ifndef CFG_MUL_ARB_FIXED_PRIO_EN
    input  logic [TAGW-1:0] ptr_i,
`endif
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [TAGW-1:0] idx_o,
    output logic            valid_o
);

    logic [TAGW-1:0] pickIdx;
    logic            found;
    int              cand;

    always_comb begin
        pickIdx = '0;
        found   = 1'b0;
        cand    = 0;
`ifdef CFG_MUL_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_i[i]) begin
                found   = 1'b1;
                pickIdx = TAGW'(i);
            end
        end
`else
        // Scan NREQ positions starting at the pointer, wrapping at NREQ.
        for (int i = 0; i < NREQ; i++) begin
            cand = (int'(ptr_i) + i) % NREQ;
            if (!found && req_i[cand]) begin
                found   = 1'b1;
                pickIdx = TAGW'(cand);
            end
        end
`endif
    end

    always_comb begin
        gnt_o = '0;
        if (found) begin
            gnt_o[pickIdx] = 1'b1;
        end
    end

    assign idx_o   = pickIdx;
    assign valid_o = found;

endmodule

// File: rtl/lm32_mul_arbiter.sv
// Shares one 3-stage pipelined 32x32 multiplier between NREQ requesters and
// routes products back in issue order. Define CFG_MUL_ARB_FIXED_PRIO_EN for fixed priority.
module lm32_mul_arbiter
    import lm32_mul_arb_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int TAGW = tag_width(NREQ)
)
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [NREQ*32-1:0] req_op0_i,
    input  logic [NREQ*32-1:0] req_op1_i,
    output logic [NREQ-1:0]   resp_valid_o,
    input  logic [NREQ-1:0]   resp_ready_i,
    output logic [31:0]       resp_data_o,
    output logic [31:0]       mul_operand_0_o,
    output logic [31:0]       mul_operand_1_o,
    output logic              mul_stall_x_o,
    output logic              mul_stall_m_o,
    input  logic [31:0]       mul_result_i
);

    mul_stage_t      stage_q [MUL_LAT];
    mul_stage_t      stage_d [MUL_LAT];
    logic [TAGW-1:0] tailTag;
    logic            tailValid;
    logic            freeze;
    logic            issue;
    logic [NREQ-1:0] reqMasked;
    logic [NREQ-1:0] pickGnt;
    logic [TAGW-1:0] pickIdx;
    logic            pickValid;

    assign tailValid = stage_q[MUL_LAT-1].valid;
    assign tailTag   = stage_q[MUL_LAT-1].tag[TAGW-1:0];

    // A finished product its owner will not take stalls every multiplier stage.
    assign freeze = tailValid & ~resp_ready_i[tailTag];

    // Nothing is accepted while reset is held.
    assign reqMasked = req_valid_i & {NREQ{rst_n_i}};

`ifdef CFG_MUL_ARB_FIXED_PRIO_EN
    lm32_mul_arb_rr #(.NREQ(NREQ), .TAGW(TAGW)) u_pick (
        .req_i   (reqMasked),
        .gnt_o   (pickGnt),
        .idx_o   (pickIdx),
        .valid_o (pickValid)
    );
`else
    logic [TAGW-1:0] rrPtr_q;
    logic [TAGW-1:0] rrPtr_d;

    lm32_mul_arb_rr #(.NREQ(NREQ), .TAGW(TAGW)) u_pick (
        .ptr_i   (rrPtr_q),
        .req_i   (reqMasked),
        .gnt_o   (pickGnt),
        .idx_o   (pickIdx),
        .valid_o (pickValid)
    );

    always_comb begin
        rrPtr_d = rrPtr_q;
        if (issue) begin
            rrPtr_d = (int'(pickIdx) == NREQ - 1) ? '0 : pickIdx + TAGW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rrPtr_q <= '0;
        end else begin
            rrPtr_q <= rrPtr_d;
        end
    end
`endif

    assign issue       = pickValid & ~freeze;
    assign req_ready_o = issue ? pickGnt : '0;

    assign mul_operand_0_o = issue ? req_op0_i[32*int'(pickIdx) +: 32] : '0;
    assign mul_operand_1_o = issue ? req_op1_i[32*int'(pickIdx) +: 32] : '0;
    assign mul_stall_x_o   = freeze;
    assign mul_stall_m_o   = freeze;

    // Bubbles shift along with real entries so tags stay aligned with the datapath.
    always_comb begin
        for (int i = 0; i < MUL_LAT; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (!freeze) begin
            stage_d[0].valid = issue;
            stage_d[0].tag   = issue ? MAX_TAGW'(pickIdx) : '0;
            for (int i = 1; i < MUL_LAT; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MUL_LAT; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    always_comb begin
        resp_valid_o = '0;
        for (int k = 0; k < NREQ; k++) begin
            resp_valid_o[k] = tailValid && (stage_q[MUL_LAT-1].tag == MAX_TAGW'(k));
        end
    end

    assign resp_data_o = mul_result_i;

endmodule

// File: tb/tb_lm32_mul_arbiter.sv
// Self-checking bench for lm32_mul_arbiter with a behavioural 3-stage multiplier
// and an in-order scoreboard. Honors CFG_MUL_ARB_FIXED_PRIO_EN for expected grants.
module tb_lm32_mul_arbiter;

    logic        clk;
    logic        rstN;
    logic [1:0]  reqValid;
    logic [1:0]  reqReady;
    logic [63:0] reqOp0;
    logic [63:0] reqOp1;
    logic [1:0]  respValid;
    logic [1:0]  respReady;
    logic [31:0] respData;
    logic [31:0] mulOp0;
    logic [31:0] mulOp1;
    logic        mulStallX;
    logic        mulStallM;
    logic [31:0] mulResult;

    typedef struct {
        int          tag;
        logic [31:0] data;
    } sbEntry_t;

    sbEntry_t    sb[$];
    int          checks;
    int          errors;
    int          expPtr;
    logic [31:0] mulA, mulB, mulP;

    lm32_mul_arbiter #(.NREQ(2)) dut (
        .clk_i           (clk),
        .rst_n_i         (rstN),
        .req_valid_i     (reqValid),
        .req_ready_o     (reqReady),
        .req_op0_i       (reqOp0),
        .req_op1_i       (reqOp1),
        .resp_valid_o    (respValid),
        .resp_ready_i    (respReady),
        .resp_data_o     (respData),
        .mul_operand_0_o (mulOp0),
        .mul_operand_1_o (mulOp1),
        .mul_stall_x_o   (mulStallX),
        .mul_stall_m_o   (mulStallM),
        .mul_result_i    (mulResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: input regs, M stage, result register; stalls hold all stages.
    initial begin
        mulA = '0; mulB = '0; mulP = '0; mulResult = '0;
    end
    always @(posedge clk) begin
        if (!mulStallX) begin
            mulA <= mulOp0;
            mulB <= mulOp1;
        end
        if (!mulStallM) begin
            mulP      <= mulA * mulB;
            mulResult <= mulP;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                                 input logic [31:0] a1, input logic [31:0] b1);
        reqValid = v;
        reqOp0   = {a1, a0};
        reqOp1   = {b1, b0};
    endtask

    task automatic waitDrain(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #3;
        end
        checkOutput(tag, sb.size(), 0);
    endtask

    function automatic int expGrant(input logic [1:0] v, input int ptr);
`ifdef CFG_MUL_ARB_FIXED_PRIO_EN
        if (v[0]) return 0;
        if (v[1]) return 1;
        return -1;
`else
        for (int i = 0; i < 2; i++) begin
            int c;
            c = (ptr + i) % 2;
            if (v[c]) return c;
        end
        return -1;
`endif
    endfunction

    // Scoreboard monitor runs after the directed negedge checks each cycle.
    always @(negedge clk) begin
        #2;
        if (rstN) begin
            for (int k = 0; k < 2; k++) begin
                if (respValid[k] && respReady[k]) begin
                    checkOutput("sb_nonempty", (sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        sbEntry_t e;
                        e = sb.pop_front();
                        checkOutput("sb_tag", k, e.tag);
                        checkOutput("sb_data", respData, e.data);
                    end
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (reqValid[k] && reqReady[k]) begin
                    sbEntry_t e;
                    logic [31:0] p;
                    p      = reqOp0[32*k +: 32] * reqOp1[32*k +: 32];
                    e.tag  = k;
                    e.data = p;
                    sb.push_back(e);
                    expPtr = (k + 1) % 2;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a0, b0, a1, b1, cnt, frozenData;
        int          eg;

        checks = 0;
        errors = 0;
        expPtr = 0;
        rstN = 1'b0;
        respReady = 2'b11;
        applyStimulus(2'b00, '0, '0, '0, '0);

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_req_ready", reqReady, 0);
        checkOutput("rst_resp_valid", respValid, 0);
        checkOutput("rst_stall_x", mulStallX, 0);
        checkOutput("rst_stall_m", mulStallM, 0);
        checkOutput("rst_op0", mulOp0, 0);
        checkOutput("rst_op1", mulOp1, 0);
        @(posedge clk); #1;
        rstN = 1'b1;

        // Single request 7 x 6, 3-cycle latency
        applyStimulus(2'b01, 32'd7, 32'd6, '0, '0);
        @(negedge clk);
        checkOutput("t1_ready", reqReady, 2'b01);
        checkOutput("t1_op0", mulOp0, 32'd7);
        checkOutput("t1_op1", mulOp1, 32'd6);
        @(posedge clk); #1;
        applyStimulus(2'b00, '0, '0, '0, '0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checkOutput("t1_lat_valid", respValid, (i == 3) ? 2'b01 : 2'b00);
        end
        checkOutput("t1_data", respData, 32'd42);
        @(posedge clk); #1;

        // Both requesters continuously valid, operands i x 3
        a0 = 32'd1; b0 = 32'd3; a1 = 32'd2; b1 = 32'd3; cnt = 32'd3;
        applyStimulus(2'b11, a0, b0, a1, b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            eg = expGrant(2'b11, expPtr);
            checkOutput("t2_grant", reqReady, (eg == 1) ? 2'b10 : 2'b01);
            checkOutput("t2_op0", mulOp0, (eg == 1) ? a1 : a0);
            @(posedge clk); #1;
            if (eg == 1) a1 = cnt; else a0 = cnt;
            cnt = cnt + 1;
            applyStimulus(2'b11, a0, b0, a1, b1);
        end
        applyStimulus(2'b00, '0, '0, '0, '0);
        repeat (3) @(negedge clk);
        #3;
        checkOutput("t2_throughput_drain", sb.size(), 0);
        @(posedge clk); #1;

        // Back-pressure on requester 1 freezes the pipe
        respReady = 2'b01;
        applyStimulus(2'b10, '0, '0, 32'd5, 32'd5);
        @(posedge clk); #1;
        applyStimulus(2'b01, 32'd9, 32'd9, '0, '0);
        @(posedge clk); #1;
        applyStimulus(2'b10, '0, '0, 32'd11, 32'd2);
        @(posedge clk); #1;
        applyStimulus(2'b01, 32'd4, 32'd4, '0, '0);
        frozenData = respData;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("t3_stall_x", mulStallX, 1);
            checkOutput("t3_stall_m", mulStallM, 1);
            checkOutput("t3_req_ready", reqReady, 0);
            checkOutput("t3_resp_valid", respValid, 2'b10);
            checkOutput("t3_data_stable", respData, frozenData);
            checkOutput("t3_data", respData, 32'd25);
            @(posedge clk); #1;
        end
        respReady = 2'b11;
        @(posedge clk); #1;
        applyStimulus(2'b00, '0, '0, '0, '0);
        waitDrain("t3_drain");
        @(posedge clk); #1;

        // Wrap-around arithmetic
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, '0);
        @(posedge clk); #1;
        applyStimulus(2'b10, '0, '0, 32'h0001_0000, 32'h0001_0000);
        @(posedge clk); #1;
        applyStimulus(2'b00, '0, '0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t4_valid_a", respValid, 2'b01);
        checkOutput("t4_data_a", respData, 32'h0000_0001);
        @(negedge clk);
        checkOutput("t4_valid_b", respValid, 2'b10);
        checkOutput("t4_data_b", respData, 32'h0000_0000);
        waitDrain("t4_drain");
        @(posedge clk); #1;

        // Asynchronous reset with three products in flight
        applyStimulus(2'b01, 32'd2, 32'd3, '0, '0);
        @(posedge clk); #1;
        applyStimulus(2'b10, '0, '0, 32'd4, 32'd5);
        @(posedge clk); #1;
        applyStimulus(2'b01, 32'd6, 32'd7, '0, '0);
        @(posedge clk); #1;
        applyStimulus(2'b00, '0, '0, '0, '0);
        checkOutput("t5_pre_rst_valid", respValid, 2'b01);
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("t5_rst_valid", respValid, 0);
        checkOutput("t5_rst_stall", mulStallX, 0);
        sb.delete();
        expPtr = 0;
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("t5_no_ghost", respValid, 0);
        end

        waitDrain("final_drain");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
